// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared raster field layout, widths and walker state encoding
package raster_pkg;
    localparam int COORD_W = 10;
    localparam int COLOR_W = 3;

    // Captured line word: {x_0, y_0, x_1, y_1, color, valid}
    localparam int X0_MSB    = 43;
    localparam int X0_LSB    = 34;
    localparam int Y0_MSB    = 33;
    localparam int Y0_LSB    = 24;
    localparam int X1_MSB    = 23;
    localparam int X1_LSB    = 14;
    localparam int Y1_MSB    = 13;
    localparam int Y1_LSB    = 4;
    localparam int COLOR_MSB = 3;
    localparam int COLOR_LSB = 1;
    localparam int VALID_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;
endpackage

// File: rtl/raster_line_setup.sv
// rtl/raster_line_setup.sv - combinational Bresenham setup: deltas, step signs, initial error
module raster_line_setup #(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0]        x0_i,
    input  logic [COORD_W-1:0]        y0_i,
    input  logic [COORD_W-1:0]        x1_i,
    input  logic [COORD_W-1:0]        y1_i,
    output logic [COORD_W-1:0]        dx_o,
    output logic [COORD_W-1:0]        dy_o,
    output logic                      sx_neg_o,
    output logic                      sy_neg_o,
    output logic signed [COORD_W+1:0] err_o
);
    always_comb begin
        sx_neg_o = (x1_i < x0_i);
        sy_neg_o = (y1_i < y0_i);
        dx_o     = sx_neg_o ? (x0_i - x1_i) : (x1_i - x0_i);
        dy_o     = sy_neg_o ? (y0_i - y1_i) : (y1_i - y0_i);
        err_o    = $signed({2'b00, dx_o}) - $signed({2'b00, dy_o});
    end
endmodule

// File: rtl/raster_line_walker.sv
// rtl/raster_line_walker.sv - walks a captured line with integer Bresenham, one pixel per accepted cycle
module raster_line_walker #(
    parameter int COORD_W = raster_pkg::COORD_W,
    parameter int COLOR_W = raster_pkg::COLOR_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [4*COORD_W+COLOR_W:0]     line_cap_reg,
    output logic                           in_ready,
    output logic                           overrun,
    output logic [COORD_W-1:0]             pix_x,
    output logic [COORD_W-1:0]             pix_y,
    output logic [COLOR_W-1:0]             pix_color,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic                           line_done
);
    localparam int ERR_W = COORD_W + 2;

    raster_pkg::state_t state_q, state_d;
    logic [COORD_W-1:0]      x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [COORD_W-1:0]      dx_q, dx_d, dy_q, dy_d;
    logic [COORD_W-1:0]      px_q, px_d, py_q, py_d;
    logic [COLOR_W-1:0]      color_q, color_d;
    logic                    sxn_q, sxn_d, syn_q, syn_d;
    logic signed [ERR_W-1:0] err_q, err_d, err_nx;

    logic [COORD_W-1:0]      su_dx, su_dy;
    logic                    su_sxn, su_syn;
    logic signed [ERR_W-1:0] su_err;

    logic signed [ERR_W:0]   e2, neg_dy, dx_ext;
    logic                    step_x, step_y, at_end;

    raster_line_setup #(.COORD_W(COORD_W)) u_setup (
        .x0_i     (x0_q),
        .y0_i     (y0_q),
        .x1_i     (x1_q),
        .y1_i     (y1_q),
        .dx_o     (su_dx),
        .dy_o     (su_dy),
        .sx_neg_o (su_sxn),
        .sy_neg_o (su_syn),
        .err_o    (su_err)
    );

    always_comb begin
        state_d = state_q;
        x0_d = x0_q; y0_d = y0_q; x1_d = x1_q; y1_d = y1_q;
        dx_d = dx_q; dy_d = dy_q; sxn_d = sxn_q; syn_d = syn_q;
        px_d = px_q; py_d = py_q; color_d = color_q; err_d = err_q;

        in_ready  = (state_q == raster_pkg::IDLE);
        pix_valid = (state_q == raster_pkg::DRAW);
        at_end    = (px_q == x1_q) && (py_q == y1_q);
        line_done = pix_valid && at_end;
        overrun   = line_cap_reg[raster_pkg::VALID_BIT] && !in_ready;

        // Both step decisions use the pre-update error
        e2     = {err_q, 1'b0};
        neg_dy = '0 - $signed({3'b000, dy_q});
        dx_ext = $signed({3'b000, dx_q});
        step_x = (e2 > neg_dy);
        step_y = (e2 < dx_ext);
        err_nx = err_q;
        if (step_x) err_nx = err_nx - $signed({2'b00, dy_q});
        if (step_y) err_nx = err_nx + $signed({2'b00, dx_q});

        case (state_q)
            raster_pkg::IDLE: begin
                if (line_cap_reg[raster_pkg::VALID_BIT]) begin
                    x0_d    = line_cap_reg[raster_pkg::X0_MSB:raster_pkg::X0_LSB];
                    y0_d    = line_cap_reg[raster_pkg::Y0_MSB:raster_pkg::Y0_LSB];
                    x1_d    = line_cap_reg[raster_pkg::X1_MSB:raster_pkg::X1_LSB];
                    y1_d    = line_cap_reg[raster_pkg::Y1_MSB:raster_pkg::Y1_LSB];
                    color_d = line_cap_reg[raster_pkg::COLOR_MSB:raster_pkg::COLOR_LSB];
                    state_d = raster_pkg::SETUP;
                end
            end
            raster_pkg::SETUP: begin
                dx_d    = su_dx;
                dy_d    = su_dy;
                sxn_d   = su_sxn;
                syn_d   = su_syn;
                err_d   = su_err;
                px_d    = x0_q;
                py_d    = y0_q;
                state_d = raster_pkg::DRAW;
            end
            raster_pkg::DRAW: begin
                if (pix_ready) begin
                    if (at_end) begin
                        state_d = raster_pkg::IDLE;
                    end else begin
                        err_d = err_nx;
                        if (step_x) px_d = sxn_q ? px_q - COORD_W'(1) : px_q + COORD_W'(1);
                        if (step_y) py_d = syn_q ? py_q - COORD_W'(1) : py_q + COORD_W'(1);
                    end
                end
            end
            default: state_d = raster_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= raster_pkg::IDLE;
            x0_q <= '0; y0_q <= '0; x1_q <= '0; y1_q <= '0;
            dx_q <= '0; dy_q <= '0; sxn_q <= 1'b0; syn_q <= 1'b0;
            px_q <= '0; py_q <= '0; color_q <= '0; err_q <= '0;
        end else begin
            state_q <= state_d;
            x0_q <= x0_d; y0_q <= y0_d; x1_q <= x1_d; y1_q <= y1_d;
            dx_q <= dx_d; dy_q <= dy_d; sxn_q <= sxn_d; syn_q <= syn_d;
            px_q <= px_d; py_q <= py_d; color_q <= color_d; err_q <= err_d;
        end
    end

    assign pix_x     = px_q;
    assign pix_y     = py_q;
    assign pix_color = color_q;
endmodule
